// File: rtl/cpu_muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: ALU mod codes ({funct7, funct3})
// and the multiply/divide sequencer states.
package cpu_muldiv_pkg;

    localparam logic [9:0] INST_ARLOG_ADD    = 10'b0000000_000;
    localparam logic [9:0] INST_ARLOG_SUB    = 10'b0100000_000;
    localparam logic [9:0] INST_ARLOG_SLL    = 10'b0000000_001;
    localparam logic [9:0] INST_ARLOG_SLT    = 10'b0000000_010;
    localparam logic [9:0] INST_ARLOG_SLTU   = 10'b0000000_011;
    localparam logic [9:0] INST_ARLOG_XOR    = 10'b0000000_100;
    localparam logic [9:0] INST_ARLOG_SRL    = 10'b0000000_101;
    localparam logic [9:0] INST_ARLOG_SRA    = 10'b0100000_101;
    localparam logic [9:0] INST_ARLOG_OR     = 10'b0000000_110;
    localparam logic [9:0] INST_ARLOG_AND    = 10'b0000000_111;

    localparam logic [9:0] INST_ARLOG_MUL    = 10'b0000001_000;
    localparam logic [9:0] INST_ARLOG_MULH   = 10'b0000001_001;
    localparam logic [9:0] INST_ARLOG_MULHSU = 10'b0000001_010;
    localparam logic [9:0] INST_ARLOG_MULHU  = 10'b0000001_011;
    localparam logic [9:0] INST_ARLOG_DIV    = 10'b0000001_100;
    localparam logic [9:0] INST_ARLOG_DIVU   = 10'b0000001_101;
    localparam logic [9:0] INST_ARLOG_REM    = 10'b0000001_110;
    localparam logic [9:0] INST_ARLOG_REMU   = 10'b0000001_111;

    typedef enum logic [1:0] {
        MULDIV_IDLE   = 2'd0,
        MULDIV_CALC   = 2'd1,
        MULDIV_FINISH = 2'd2
    } muldiv_state_e;

    // All eight M-extension ops share funct7=0000001; funct3 selects the op.
    function automatic logic is_m_op(input logic [9:0] code);
        return code[9:3] == 7'b0000001;
    endfunction

    function automatic logic is_div_op(input logic [9:0] code);
        return is_m_op(code) && code[2];
    endfunction

endpackage

// File: rtl/cpu_divider_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and shift the quotient bit in.
module cpu_divider_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        shifted = {rem_in, quo_in[XLEN-1]};
        diff    = shifted - {1'b0, divisor};
        // Top bit of diff is the borrow: divisor did not fit, keep the shifted remainder.
        if (diff[XLEN]) begin
            rem_out = shifted[XLEN-1:0];
            quo_out = {quo_in[XLEN-2:0], 1'b0};
        end else begin
            rem_out = diff[XLEN-1:0];
            quo_out = {quo_in[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/cpu_muldiv.sv
// Iterative RV32M multiply/divide unit (33-cycle latency). Defining CPU_MULDIV_FAST_MUL_EN
// replaces the iterative multiply with a single-cycle combinational multiply (latency 1).
module cpu_muldiv
    import cpu_muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [9:0]      mod,
    input  logic            start,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            invalid_opcode
);

    muldiv_state_e     state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [9:0]        op_q, op_d;
    logic [2*XLEN-1:0] work_q, work_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic              a_neg_q, a_neg_d;
    logic              b_neg_q, b_neg_d;
    logic              div0_q, div0_d;
    logic              ovf_q, ovf_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              done_q, done_d;

    logic              a_signed, b_signed;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN-1:0]   div_rem, div_quo;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;
    logic [XLEN-1:0]   fin_result;

    always_comb begin
        a_signed = (mod == INST_ARLOG_MUL) || (mod == INST_ARLOG_MULH) ||
                   (mod == INST_ARLOG_MULHSU) || (mod == INST_ARLOG_DIV) ||
                   (mod == INST_ARLOG_REM);
        b_signed = (mod == INST_ARLOG_MUL) || (mod == INST_ARLOG_MULH) ||
                   (mod == INST_ARLOG_DIV) || (mod == INST_ARLOG_REM);
        a_neg    = a_signed && operand_a[XLEN-1];
        b_neg    = b_signed && operand_b[XLEN-1];
        a_mag    = a_neg ? (~operand_a + 1'b1) : operand_a;
        b_mag    = b_neg ? (~operand_b + 1'b1) : operand_b;
        invalid_opcode = !is_m_op(mod);
    end

`ifdef CPU_MULDIV_FAST_MUL_EN
    logic signed [2*XLEN-1:0] fast_a, fast_b, fast_prod;

    always_comb begin
        fast_a    = {{XLEN{a_signed && operand_a[XLEN-1]}}, operand_a};
        fast_b    = {{XLEN{b_signed && operand_b[XLEN-1]}}, operand_b};
        fast_prod = fast_a * fast_b;
    end
`endif

    // Multiply: work_q = {accumulator, multiplier}; add multiplicand on LSB, shift right.
    always_comb begin
        mul_sum  = {1'b0, work_q[2*XLEN-1:XLEN]} + (work_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, work_q[XLEN-1:1]};
    end

    // Divide: work_q = {partial remainder, dividend/quotient}.
    cpu_divider_step #(.XLEN(XLEN)) u_div_step (
        .rem_in  (work_q[2*XLEN-1:XLEN]),
        .quo_in  (work_q[XLEN-1:0]),
        .divisor (opnd_q),
        .rem_out (div_rem),
        .quo_out (div_quo)
    );

    // With a zero divisor the restoring loop leaves |a| as remainder, so the signed
    // remainder already equals operand_a; only the quotient needs forcing.
    always_comb begin
        prod_fix = (a_neg_q ^ b_neg_q) ? (~work_q + 1'b1) : work_q;
        quo_fix  = (a_neg_q ^ b_neg_q) ? (~work_q[XLEN-1:0] + 1'b1) : work_q[XLEN-1:0];
        rem_fix  = a_neg_q ? (~work_q[2*XLEN-1:XLEN] + 1'b1) : work_q[2*XLEN-1:XLEN];
        case (op_q)
            INST_ARLOG_MUL:  fin_result = prod_fix[XLEN-1:0];
            INST_ARLOG_DIV:  fin_result = div0_q ? '1 : (ovf_q ? {1'b1, {(XLEN-1){1'b0}}} : quo_fix);
            INST_ARLOG_DIVU: fin_result = div0_q ? '1 : quo_fix;
            INST_ARLOG_REM:  fin_result = ovf_q ? '0 : rem_fix;
            INST_ARLOG_REMU: fin_result = rem_fix;
            default:         fin_result = prod_fix[2*XLEN-1:XLEN];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        work_d   = work_q;
        opnd_d   = opnd_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            MULDIV_IDLE: begin
                if (start && !invalid_opcode) begin
                    op_d    = mod;
                    a_neg_d = a_neg;
                    b_neg_d = b_neg;
                    cnt_d   = '0;
                    div0_d  = is_div_op(mod) && (operand_b == '0);
                    ovf_d   = ((mod == INST_ARLOG_DIV) || (mod == INST_ARLOG_REM)) &&
                              (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (operand_b == '1);
                    if (is_div_op(mod)) begin
                        work_d = {{XLEN{1'b0}}, a_mag};
                        opnd_d = b_mag;
                    end else begin
                        work_d = {{XLEN{1'b0}}, b_mag};
                        opnd_d = a_mag;
                    end
                    state_d = MULDIV_CALC;
`ifdef CPU_MULDIV_FAST_MUL_EN
                    if (!is_div_op(mod)) begin
                        work_d  = fast_prod;
                        a_neg_d = 1'b0;
                        b_neg_d = 1'b0;
                        state_d = MULDIV_FINISH;
                    end
`endif
                end
            end
            MULDIV_CALC: begin
                work_d = op_q[2] ? {div_rem, div_quo} : mul_next;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = MULDIV_FINISH;
                end
            end
            MULDIV_FINISH: begin
                result_d = fin_result;
                done_d   = 1'b1;
                state_d  = MULDIV_IDLE;
            end
            default: state_d = MULDIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= MULDIV_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            work_q   <= '0;
            opnd_q   <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            work_q   <= work_d;
            opnd_q   <= opnd_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        busy   = (state_q != MULDIV_IDLE);
        done   = done_q;
        result = result_q;
    end

endmodule

// File: tb/tb_cpu_muldiv.sv
// Self-checking bench for cpu_muldiv: arithmetic reference model with a countdown
// latency model, per-cycle output comparison, and directed literal checks.
module tb_cpu_muldiv;
    import cpu_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  mod;
    logic        start;
    logic [31:0] operand_a, operand_b;
    logic        busy, done, invalid_opcode;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;

`ifdef CPU_MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    always #5 clk = ~clk;

    cpu_muldiv #(.XLEN(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .mod            (mod),
        .start          (start),
        .operand_a      (operand_a),
        .operand_b      (operand_b),
        .busy           (busy),
        .done           (done),
        .result         (result),
        .invalid_opcode (invalid_opcode)
    );

    function automatic logic tb_is_m(input logic [9:0] m);
        return m inside {INST_ARLOG_MUL, INST_ARLOG_MULH, INST_ARLOG_MULHSU, INST_ARLOG_MULHU,
                         INST_ARLOG_DIV, INST_ARLOG_DIVU, INST_ARLOG_REM, INST_ARLOG_REMU};
    endfunction

    function automatic logic tb_is_div(input logic [9:0] m);
        return m inside {INST_ARLOG_DIV, INST_ARLOG_DIVU, INST_ARLOG_REM, INST_ARLOG_REMU};
    endfunction

    // Reference semantics straight from the RV32M definition using 64-bit integers.
    function automatic logic [31:0] ref_result(input logic [9:0] m, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (m)
            INST_ARLOG_MUL:    begin p = sa * sb; return p[31:0]; end
            INST_ARLOG_MULH:   begin p = sa * sb; return p[63:32]; end
            INST_ARLOG_MULHSU: begin p = sa * ub; return p[63:32]; end
            INST_ARLOG_MULHU:  begin p = 64'(a) * 64'(b); return p[63:32]; end
            INST_ARLOG_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            INST_ARLOG_REM: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            INST_ARLOG_DIVU: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            INST_ARLOG_REMU: begin
                if (b == 32'd0) return a;
                p = ua % ub; return p[31:0];
            end
            default: return 32'd0;
        endcase
    endfunction

    // Model: idle accepts a valid start, then counts down the op latency; done on reaching zero.
    int          m_left;
    logic        m_done;
    logic [31:0] m_pending, m_result;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left    <= 0;
            m_done    <= 1'b0;
            m_pending <= 32'd0;
            m_result  <= 32'd0;
        end else if (m_left == 0) begin
            m_done <= 1'b0;
            if (start && tb_is_m(mod)) begin
                m_pending <= ref_result(mod, operand_a, operand_b);
                m_left    <= tb_is_div(mod) ? DIV_LAT : MUL_LAT;
            end
        end else begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) m_result <= m_pending;
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check32("cyc_busy", {31'd0, busy}, {31'd0, m_left != 0});
            check32("cyc_done", {31'd0, done}, {31'd0, m_done});
            check32("cyc_result", result, m_result);
            check32("cyc_invalid", {31'd0, invalid_opcode}, {31'd0, !tb_is_m(mod)});
        end
    end

    // Issue one op, scramble operands while busy, measure latency, check the literal result.
    task automatic run_op(input string name, input logic [9:0] m, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        lat       = 0;
        mod       = m;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
        for (int n = 1; n <= 100 && lat == 0; n++) begin
            @(posedge clk); #1;
            if (done) lat = n;
        end
        if (lat == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no done expected done within 100 cycles", name);
        end else begin
            check32(name, result, exp);
            check32({name, "_lat"}, lat, exp_lat);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        rst = 1'b1; start = 1'b0; mod = INST_ARLOG_ADD; operand_a = '0; operand_b = '0;
        #22 rst = 1'b0;
        @(posedge clk); #1;
        check32("rst_busy", {31'd0, busy}, 32'd0);
        check32("rst_done", {31'd0, done}, 32'd0);
        check32("rst_result", result, 32'd0);

        run_op("mul_7_m3",      INST_ARLOG_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run_op("mulhu_max",     INST_ARLOG_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_op("mulhsu_m1_2",   INST_ARLOG_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, MUL_LAT);
        run_op("mulh_min_min",  INST_ARLOG_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT);
        run_op("mul_m1_m1",     INST_ARLOG_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         MUL_LAT);
        run_op("mulhu_2p31_2",  INST_ARLOG_MULHU,  32'h8000_0000,  32'd2,         32'd1,         MUL_LAT);
        run_op("div_ovf",       INST_ARLOG_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, DIV_LAT);
        run_op("rem_ovf",       INST_ARLOG_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         DIV_LAT);
        run_op("rem_m7_2",      INST_ARLOG_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, DIV_LAT);
        run_op("div_m7_2",      INST_ARLOG_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, DIV_LAT);
        run_op("div_100_m7",    INST_ARLOG_DIV,    32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, DIV_LAT);
        run_op("rem_100_m7",    INST_ARLOG_REM,    32'd100,        32'hFFFF_FFF9, 32'd2,         DIV_LAT);
        run_op("divu_5_0",      INST_ARLOG_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, DIV_LAT);
        run_op("remu_5_0",      INST_ARLOG_REMU,   32'd5,          32'd0,         32'd5,         DIV_LAT);
        run_op("div_m7_0",      INST_ARLOG_DIV,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, DIV_LAT);
        run_op("rem_m7_0",      INST_ARLOG_REM,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, DIV_LAT);
        run_op("remu_100_7",    INST_ARLOG_REMU,   32'd100,        32'd7,         32'd2,         DIV_LAT);

        // Start pulses while busy must be ignored.
        dones = 0;
        mod = INST_ARLOG_DIVU; operand_a = 32'd1000; operand_b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mod = INST_ARLOG_MUL;
        for (int n = 1; n <= 45; n++) begin
            @(posedge clk); #1;
            start = (n == 3 || n == 10);
            if (done) dones++;
        end
        start = 1'b0;
        check32("busy_start_dones", dones, 32'd1);
        check32("busy_start_result", result, 32'd333);

        // Invalid op code: flagged, never accepted.
        mod = INST_ARLOG_ADD; start = 1'b1;
        #1 check32("inv_flag", {31'd0, invalid_opcode}, 32'd1);
        @(posedge clk); #1;
        check32("inv_busy", {31'd0, busy}, 32'd0);
        start = 1'b0;
        @(posedge clk); #1;
        check32("inv_busy2", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-calculation.
        mod = INST_ARLOG_DIV; operand_a = 32'h7FFF_FFFF; operand_b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (16) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check32("arst_busy", {31'd0, busy}, 32'd0);
        check32("arst_done", {31'd0, done}, 32'd0);
        check32("arst_result", result, 32'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        run_op("divu_100_7", INST_ARLOG_DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
